// File: rtl/vio_pok_ctrl_pkg.sv
// rtl/vio_pok_ctrl_pkg.sv - shared types and helpers for the VIO power-good conditioner
//   vio_pok_state_e : debounce FSM state, encoding is visible on state_o
//   cnt_width()     : debounce counter width for given qualify windows
package vio_pok_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_UP  = 2'd1,
    ST_ON  = 2'd2,
    ST_DN  = 2'd3
  } vio_pok_state_e;

  // Wide enough to hold the larger of the two qualify windows.
  function automatic int unsigned cnt_width(input int unsigned on_cycles,
                                            input int unsigned off_cycles);
    int unsigned max_cycles;
    max_cycles = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/vio_pok_sync.sv
// rtl/vio_pok_sync.sv - multi-flop synchronizer for the raw power-good level
//   clk_i  : destination clock
//   rst_i  : asynchronous active-high reset, clears the chain to 0
//   d_i    : asynchronous input level
//   q_o    : synchronized level, SyncStages flops after d_i
module vio_pok_sync #(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SyncStages-1:0] sync_q;
  logic [SyncStages-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], d_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SyncStages-1];

endmodule

// File: rtl/vio_pok_ctrl.sv
// rtl/vio_pok_ctrl.sv - synchronizes and debounces the VIO power-good level
//   clk_i        : block clock
//   rst_i        : asynchronous active-high reset
//   en_i         : controller enable, 0 forces OFF
//   clr_i        : synchronous clear of glitch_cnt_o
//   vio_pok_a_i  : raw asynchronous power-good level
//   vio_pok_o    : filtered power good (high in ON and DN)
//   vio_rise_o   : pulse on UP->ON
//   vio_fall_o   : pulse on entry to OFF from ON/DN
//   glitch_o     : pulse on DN->ON abort
//   glitch_cnt_o : saturating count of glitch_o
//   state_o      : current FSM state
module vio_pok_ctrl
  import vio_pok_ctrl_pkg::*;
#(
  parameter int SyncStages = 2,
  parameter int OnCycles   = 16,
  parameter int OffCycles  = 4,
  parameter int GlitchCntW = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  vio_pok_a_i,
  output logic                  vio_pok_o,
  output logic                  vio_rise_o,
  output logic                  vio_fall_o,
  output logic                  glitch_o,
  output logic [GlitchCntW-1:0] glitch_cnt_o,
  output logic [1:0]            state_o
);

  localparam int CntW = cnt_width(OnCycles, OffCycles);
  localparam logic [CntW-1:0] OnLast  = CntW'(OnCycles - 1);
  localparam logic [CntW-1:0] OffLast = CntW'(OffCycles - 1);

  logic pok_s;

  vio_pok_sync #(
    .SyncStages(SyncStages)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (vio_pok_a_i),
    .q_o  (pok_s)
  );

  vio_pok_state_e        state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  pok_q, pok_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic                  glitch_q, glitch_d;
  logic [GlitchCntW-1:0] glitch_cnt_q, glitch_cnt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = 1'b0;

    if (!en_i) begin
      // Disable wins over everything, including a pending DN abort.
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (pok_s) begin
            state_d = ST_UP;
            cnt_d   = '0;
          end
        end
        ST_UP: begin
          if (!pok_s) begin
            // Any low sample throws away the partial qualification.
            state_d = ST_OFF;
            cnt_d   = '0;
          end else if (cnt_q == OnLast) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_ON: begin
          if (!pok_s) begin
            state_d = ST_DN;
            cnt_d   = '0;
          end
        end
        ST_DN: begin
          if (pok_s) begin
            state_d  = ST_ON;
            cnt_d    = '0;
            glitch_d = 1'b1;
          end else if (cnt_q == OffLast) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs follow next-state so they change on the same edge as the FSM.
    pok_d  = (state_d == ST_ON) || (state_d == ST_DN);
    rise_d = (state_q == ST_UP) && (state_d == ST_ON);
    fall_d = ((state_q == ST_ON) || (state_q == ST_DN)) && (state_d == ST_OFF);

    glitch_cnt_d = glitch_cnt_q;
    if (clr_i) begin
      glitch_cnt_d = '0;
    end else if (glitch_d && (glitch_cnt_q != {GlitchCntW{1'b1}})) begin
      glitch_cnt_d = glitch_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      pok_q        <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      glitch_q     <= 1'b0;
      glitch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pok_q        <= pok_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      glitch_q     <= glitch_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign vio_pok_o    = pok_q;
  assign vio_rise_o   = rise_q;
  assign vio_fall_o   = fall_q;
  assign glitch_o     = glitch_q;
  assign glitch_cnt_o = glitch_cnt_q;
  assign state_o      = state_q;

endmodule
